// File: rtl/alu_result_disp.sv
// Result display for the 4-bit ALU. It captures one result with a valid/ready handshake and holds
// it for HOLD_CYCLES cycles. It drives a value digit and a sign/carry digit, both active-low.
module alu_result_disp #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned BLINK_DIV   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] res,
  input  logic       car,
  input  logic       of,
  input  logic [2:0] ctrl,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic       busy
);

  localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_off_q, blink_off_d;
  logic [3:0]        res_q;
  logic              car_q, of_q, valid_q;
  logic [2:0]        ctrl_q;
  logic              capture;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    capture  = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          hold_d  = HoldLoad;
          state_d = StHold;
        end
      end
      StHold: begin
        busy = 1'b1;
        if (hold_q == '0) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new capture restarts the blink so the value is always shown first.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_off_d = blink_off_q;
    if (capture) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      res_q       <= '0;
      car_q       <= 1'b0;
      of_q        <= 1'b0;
      ctrl_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      if (capture) begin
        res_q   <= res;
        car_q   <= car;
        of_q    <= of;
        ctrl_q  <= ctrl;
        valid_q <= 1'b1;
      end
    end
  end

  logic       neg;
  logic [3:0] mag;

  // Only add/sub results are two's complement; the magnitude of -8 wraps back to 8.
  always_comb begin
    neg  = (ctrl_q[2:1] == 2'b00) && res_q[3];
    mag  = neg ? (4'd0 - res_q) : res_q;
    seg0 = 8'hFF;
    seg1 = 8'hFF;
    if (valid_q) begin
      seg0 = (of_q && blink_off_q) ? 8'hFF : hex7(mag);
      seg1 = {~car_q, (neg ? 7'h3F : 7'h7F)};
    end
  end

endmodule
